alu_muldiv_control: RTL and testbench

- Next-generation ALU control for the RV32 sequential core.
- Decodes alu_op/funct3/funct7 into an extended 4-bit ALU code covering full RV32I R/I arithmetic.
- Adds an iterative RV32M multiply/divide engine with a request/done handshake and a stall output that holds the PC.
- Sits between the main control unit and the ALU/writeback mux.

---
 rtl/alu_pkg.sv | 44 ++++
 rtl/alu_muldiv_control_muldiv_iter.sv | 185 ++++++++++++++++++
 rtl/alu_muldiv_control.sv | 84 ++++++++
 tb/tb_alu_muldiv_control.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared encodings for the RV32 ALU control and the iterative
// RV32M multiply/divide engine.
//   ALU_*    4-bit ALU operation codes driven to the ALU
//   ALUOP_*  2-bit alu_op class from the main control unit
//   F7_*     funct7 patterns that select alternate ops / the M extension
//   F3_*     RV32M funct3 encodings
//   md_state_t  multiply/divide engine states
package alu_pkg;

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_XOR  = 4'b0011;
    localparam logic [3:0] ALU_SLL  = 4'b0100;
    localparam logic [3:0] ALU_SRL  = 4'b0101;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SLT  = 4'b0111;
    localparam logic [3:0] ALU_SLTU = 4'b1000;
    localparam logic [3:0] ALU_SRA  = 4'b1001;

    localparam logic [1:0] ALUOP_MEM = 2'b00;
    localparam logic [1:0] ALUOP_BR  = 2'b01;
    localparam logic [1:0] ALUOP_R   = 2'b10;
    localparam logic [1:0] ALUOP_I   = 2'b11;

    localparam logic [6:0] F7_ALT  = 7'b0100000;
    localparam logic [6:0] F7_MEXT = 7'b0000001;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef enum logic [1:0] {
        MD_IDLE = 2'b00,
        MD_CALC = 2'b01,
        MD_DONE = 2'b10
    } md_state_t;

endpackage

// File: rtl/alu_muldiv_control_muldiv_iter.sv
// muldiv_iter: one-bit-per-cycle RV32M engine.
//   clk, rst        clock, async active-high reset
//   start_i         accept a new op (only honoured in IDLE)
//   flush_i         abort an op in CALC/DONE; wins over completion
//   funct3_i        M-op select, latched at accept
//   a_i, b_i        operands, latched (as magnitudes) at accept
//   busy_o          engine not IDLE
//   done_o          one-cycle completion pulse
//   result_o        result; valid with done_o, held until the next completion
module muldiv_iter
    import alu_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = $clog2(XLEN) + 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start_i,
    input  logic            flush_i,
    input  logic [2:0]      funct3_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    output logic            busy_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o
);

    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    md_state_t             state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [2*XLEN-1:0]     acc_q, acc_d;
    logic [XLEN-1:0]       opnd_q, opnd_d;
    logic [2:0]            op_q, op_d;
    logic                  neg_q, neg_d;
    logic                  special_q, special_d;
    logic [XLEN-1:0]       res_q, res_d;

    // ---- accept-time decode ----
    logic            is_div, is_rem, a_signed, b_signed, a_neg, b_neg;
    logic [XLEN-1:0] a_abs, b_abs, spec_val;
    logic            div_zero, ovf;

    assign is_div   = funct3_i[2];
    assign is_rem   = funct3_i[2] & funct3_i[1];
    assign a_signed = (funct3_i == F3_MULH) || (funct3_i == F3_MULHSU) ||
                      (funct3_i == F3_DIV)  || (funct3_i == F3_REM);
    assign b_signed = (funct3_i == F3_MULH) || (funct3_i == F3_DIV) ||
                      (funct3_i == F3_REM);
    assign a_neg    = a_signed & a_i[XLEN-1];
    assign b_neg    = b_signed & b_i[XLEN-1];
    assign a_abs    = a_neg ? -a_i : a_i;
    assign b_abs    = b_neg ? -b_i : b_i;
    assign div_zero = is_div && (b_i == '0);
    assign ovf      = ((funct3_i == F3_DIV) || (funct3_i == F3_REM)) &&
                      (a_i == MIN_NEG) && (b_i == '1);

    // Divide-by-zero and signed overflow are fully known at accept.
    always_comb begin
        spec_val = '0;
        if (div_zero)
            spec_val = is_rem ? a_i : '1;
        else
            spec_val = is_rem ? '0 : a_i;
    end

    // ---- iteration datapath ----
    logic [XLEN-1:0] hi, lo;
    logic [XLEN:0]   sum, shifted, diff;
    logic            ge;
    logic [2*XLEN-1:0] step_mul, step_div;

    assign hi = acc_q[2*XLEN-1:XLEN];
    assign lo = acc_q[XLEN-1:0];

    // Shift-add: lo holds the multiplier, hi accumulates; shift right each step.
    assign sum      = {1'b0, hi} + (lo[0] ? {1'b0, opnd_q} : {(XLEN+1){1'b0}});
    assign step_mul = {sum, lo[XLEN-1:1]};

    // Restoring divide: hi is the partial remainder, lo shifts the dividend
    // out and the quotient in.
    assign shifted  = {hi, lo[XLEN-1]};
    assign ge       = shifted >= {1'b0, opnd_q};
    assign diff     = shifted - {1'b0, opnd_q};
    assign step_div = ge ? {diff[XLEN-1:0], lo[XLEN-2:0], 1'b1}
                         : {shifted[XLEN-1:0], lo[XLEN-2:0], 1'b0};

    // ---- sign correction / result select ----
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quo, rem, final_res;

    assign prod = neg_q ? -acc_q : acc_q;
    assign quo  = neg_q ? -lo : lo;
    assign rem  = neg_q ? -hi : hi;

    always_comb begin
        final_res = lo;
        if (!special_q) begin
            unique case (op_q)
                F3_MUL:                       final_res = prod[XLEN-1:0];
                F3_MULH, F3_MULHSU, F3_MULHU: final_res = prod[2*XLEN-1:XLEN];
                F3_DIV, F3_DIVU:              final_res = quo;
                default:                      final_res = rem;
            endcase
        end
    end

    // ---- FSM ----
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        opnd_d    = opnd_q;
        op_d      = op_q;
        neg_d     = neg_q;
        special_d = special_q;
        res_d     = res_q;
        unique case (state_q)
            MD_IDLE: begin
                if (start_i) begin
                    op_d  = funct3_i;
                    cnt_d = CNT_W'(XLEN);
                    // Remainder takes the dividend's sign; everything else
                    // is negative when the (signed) operand signs differ.
                    neg_d = is_rem ? a_neg : (a_neg ^ b_neg);
                    if (div_zero || ovf) begin
                        special_d = 1'b1;
                        neg_d     = 1'b0;
                        acc_d     = {{XLEN{1'b0}}, spec_val};
                        state_d   = MD_DONE;
                    end else begin
                        special_d = 1'b0;
                        acc_d     = {{XLEN{1'b0}}, is_div ? a_abs : b_abs};
                        opnd_d    = is_div ? b_abs : a_abs;
                        state_d   = MD_CALC;
                    end
                end
            end
            MD_CALC: begin
                acc_d = op_q[2] ? step_div : step_mul;
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1))
                    state_d = MD_DONE;
            end
            MD_DONE: begin
                res_d   = final_res;
                state_d = MD_IDLE;
            end
            default: state_d = MD_IDLE;
        endcase
        if (flush_i && (state_q != MD_IDLE)) begin
            state_d = MD_IDLE;
            res_d   = res_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= MD_IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            opnd_q    <= '0;
            op_q      <= '0;
            neg_q     <= 1'b0;
            special_q <= 1'b0;
            res_q     <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            opnd_q    <= opnd_d;
            op_q      <= op_d;
            neg_q     <= neg_d;
            special_q <= special_d;
            res_q     <= res_d;
        end
    end

    assign busy_o   = (state_q != MD_IDLE);
    assign done_o   = (state_q == MD_DONE) && !flush_i;
    // During DONE the fresh result is presented directly; it lands in res_q
    // on the same edge, so the output is continuous afterwards.
    assign result_o = done_o ? final_res : res_q;

endmodule

// File: rtl/alu_muldiv_control.sv
// alu_muldiv_control: RV32IM ALU control.
//   clk, rst              clock, async active-high reset
//   alu_op                00 load/store, 01 branch, 10 R-type, 11 I-type
//   funct3, funct7        instruction fields (funct7 = imm[11:5] for I-type)
//   md_req                instruction valid in execute; qualifies M-op start
//   flush                 abort an in-progress M-op
//   operand_a, operand_b  rs1 / rs2 values
//   alu_control           4-bit ALU code (combinational)
//   is_mext               instruction is an RV32M op
//   md_busy, md_done      engine busy / one-cycle completion
//   md_result             M-op result, held until the next completion
//   stall                 hold the PC while an M-op is outstanding
module alu_muldiv_control
    import alu_pkg::*;
#(
    parameter int XLEN = 32,
    localparam int CNT_W = $clog2(XLEN) + 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [1:0]      alu_op,
    input  logic [2:0]      funct3,
    input  logic [6:0]      funct7,
    input  logic            md_req,
    input  logic            flush,
    input  logic [XLEN-1:0] operand_a,
    input  logic [XLEN-1:0] operand_b,
    output logic [3:0]      alu_control,
    output logic            is_mext,
    output logic            md_busy,
    output logic            md_done,
    output logic [XLEN-1:0] md_result,
    output logic            stall
);

    logic md_start;

    assign is_mext = (alu_op == ALUOP_R) && (funct7 == F7_MEXT);

    always_comb begin
        alu_control = ALU_ADD;
        unique case (alu_op)
            ALUOP_MEM: alu_control = ALU_ADD;
            ALUOP_BR:  alu_control = ALU_SUB;
            default: begin
                if (!is_mext) begin
                    unique case (funct3)
                        // No SUBI: only R-type looks at funct7 here.
                        3'b000: alu_control = ((alu_op == ALUOP_R) && (funct7 == F7_ALT))
                                              ? ALU_SUB : ALU_ADD;
                        3'b001: alu_control = ALU_SLL;
                        3'b010: alu_control = ALU_SLT;
                        3'b011: alu_control = ALU_SLTU;
                        3'b100: alu_control = ALU_XOR;
                        3'b101: alu_control = (funct7 == F7_ALT) ? ALU_SRA : ALU_SRL;
                        3'b110: alu_control = ALU_OR;
                        default: alu_control = ALU_AND;
                    endcase
                end
            end
        endcase
    end

    assign md_start = is_mext & md_req & ~flush;

    muldiv_iter #(
        .XLEN  (XLEN),
        .CNT_W (CNT_W)
    ) u_muldiv (
        .clk      (clk),
        .rst      (rst),
        .start_i  (md_start),
        .flush_i  (flush),
        .funct3_i (funct3),
        .a_i      (operand_a),
        .b_i      (operand_b),
        .busy_o   (md_busy),
        .done_o   (md_done),
        .result_o (md_result)
    );

    assign stall = is_mext & md_req & ~md_done;

endmodule

// File: tb/tb_alu_muldiv_control.sv
module tb_alu_muldiv_control;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  alu_op = '0;
    logic [2:0]  funct3 = '0;
    logic [6:0]  funct7 = '0;
    logic        md_req = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] operand_a = '0;
    logic [31:0] operand_b = '0;
    logic [3:0]  alu_control;
    logic        is_mext;
    logic        md_busy;
    logic        md_done;
    logic [31:0] md_result;
    logic        stall;

    int pass_cnt = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    alu_muldiv_control #(.XLEN(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .alu_op     (alu_op),
        .funct3     (funct3),
        .funct7     (funct7),
        .md_req     (md_req),
        .flush      (flush),
        .operand_a  (operand_a),
        .operand_b  (operand_b),
        .alu_control(alu_control),
        .is_mext    (is_mext),
        .md_busy    (md_busy),
        .md_done    (md_done),
        .md_result  (md_result),
        .stall      (stall)
    );

    typedef struct {
        logic [1:0] op;
        logic [2:0] f3;
        logic [6:0] f7;
        logic [3:0] ctl;
        logic       mext;
    } dec_vec_t;

    typedef struct {
        string       nm;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        int          lat;
    } md_vec_t;

    dec_vec_t dv[$];
    md_vec_t  mv[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // Called just after a rising edge. Accept edge is the next rising edge.
    task automatic do_mop(input string nm, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_res,
                          input int exp_lat, input bit hold);
        int  lat;
        int  stl;
        bit  got;
        lat = 0; stl = 0; got = 0;
        alu_op = 2'b10; funct7 = 7'b0000001; funct3 = f3;
        operand_a = a; operand_b = b; md_req = 1'b1;
        @(negedge clk);
        if (stall) stl++;
        @(posedge clk);
        #1;
        operand_a = ~a;   // must be ignored after accept
        operand_b = ~b;
        for (int i = 1; i <= 60 && !got; i++) begin
            @(negedge clk);
            if (md_done) begin
                got = 1; lat = i;
                chk($sformatf("%s result", nm), 64'(md_result), 64'(exp_res));
            end else begin
                if (stall) stl++;
                @(posedge clk);
            end
        end
        chk($sformatf("%s latency", nm), 64'(lat), 64'(exp_lat));
        chk($sformatf("%s stall cycles", nm), 64'(stl), 64'(exp_lat));
        @(posedge clk);
        #1;
        if (!hold) begin
            md_req = 1'b0; alu_op = 2'b00; funct7 = '0;
            @(negedge clk);
            chk($sformatf("%s busy after", nm), 64'(md_busy), 64'd0);
            chk($sformatf("%s result held", nm), 64'(md_result), 64'(exp_res));
            @(posedge clk);
            #1;
        end
    endtask

    logic [3:0] r_plain[8] = '{4'b0010, 4'b0100, 4'b0111, 4'b1000, 4'b0011, 4'b0101, 4'b0001, 4'b0000};
    logic [3:0] r_alt[8]   = '{4'b0110, 4'b0100, 4'b0111, 4'b1000, 4'b0011, 4'b1001, 4'b0001, 4'b0000};
    logic [3:0] i_alt[8]   = '{4'b0010, 4'b0100, 4'b0111, 4'b1000, 4'b0011, 4'b1001, 4'b0001, 4'b0000};

    initial begin
        dec_vec_t d;
        int       dn;

        // ---------------- decode table ----------------
        for (int op = 0; op < 4; op++)
            for (int f = 0; f < 8; f++)
                for (int alt = 0; alt < 2; alt++) begin
                    d.op = 2'(op); d.f3 = 3'(f);
                    d.f7 = alt ? 7'b0100000 : 7'b0000000;
                    d.mext = 1'b0;
                    if (op == 0)      d.ctl = 4'b0010;
                    else if (op == 1) d.ctl = 4'b0110;
                    else if (op == 2) d.ctl = alt ? r_alt[f] : r_plain[f];
                    else              d.ctl = alt ? i_alt[f] : r_plain[f];
                    dv.push_back(d);
                end
        for (int f = 0; f < 8; f++)
            dv.push_back('{2'b10, 3'(f), 7'b0000001, 4'b0010, 1'b1});
        dv.push_back('{2'b11, 3'b000, 7'b0000001, 4'b0010, 1'b0});
        dv.push_back('{2'b11, 3'b101, 7'b0000001, 4'b0101, 1'b0});
        dv.push_back('{2'b00, 3'b101, 7'b0000001, 4'b0010, 1'b0});

        // ---------------- M-op table ----------------
        mv.push_back('{"MUL",        3'd0, 32'hFFFFFFFD, 32'd7,        32'hFFFFFFEB, 33});
        mv.push_back('{"MULH",       3'd1, 32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 33});
        mv.push_back('{"MULHSU",     3'd2, 32'd7,        32'hFFFFFFFD, 32'd6,        33});
        mv.push_back('{"MULHU",      3'd3, 32'hFFFFFFFD, 32'd7,        32'd6,        33});
        mv.push_back('{"MULHU max",  3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33});
        mv.push_back('{"DIV -7/2",   3'd4, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33});
        mv.push_back('{"REM -7/2",   3'd6, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33});
        mv.push_back('{"DIV 7/-2",   3'd4, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 33});
        mv.push_back('{"REM 7/-2",   3'd6, 32'd7,        32'hFFFFFFFE, 32'd1,        33});
        mv.push_back('{"DIVU big",   3'd5, 32'h80000000, 32'hFFFFFFFF, 32'd0,        33});
        mv.push_back('{"DIVU /0",    3'd5, 32'h00001234, 32'd0,        32'hFFFFFFFF, 1});
        mv.push_back('{"DIV /0",     3'd4, 32'h00001234, 32'd0,        32'hFFFFFFFF, 1});
        mv.push_back('{"REM /0",     3'd6, 32'h00001234, 32'd0,        32'h00001234, 1});
        mv.push_back('{"REMU /0",    3'd7, 32'h00001234, 32'd0,        32'h00001234, 1});
        mv.push_back('{"DIV ovf",    3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1});
        mv.push_back('{"REM ovf",    3'd6, 32'h80000000, 32'hFFFFFFFF, 32'd0,        1});
        mv.push_back('{"DIVU 100/7", 3'd5, 32'd100,      32'd7,        32'd14,       33});
        mv.push_back('{"REMU 100/7", 3'd7, 32'd100,      32'd7,        32'd2,        33});

        // ---------------- reset ----------------
        repeat (2) @(posedge clk);
        #1;
        chk("reset busy",   64'(md_busy),   64'd0);
        chk("reset done",   64'(md_done),   64'd0);
        chk("reset result", 64'(md_result), 64'd0);
        chk("reset stall",  64'(stall),     64'd0);
        rst = 1'b0;

        // ---------------- decode sweep ----------------
        dn = 0;
        foreach (dv[k]) begin
            alu_op = dv[k].op; funct3 = dv[k].f3; funct7 = dv[k].f7;
            #1;
            chk($sformatf("decode[%0d] op=%0d f3=%0d f7=%h ctl", dn, dv[k].op, dv[k].f3, dv[k].f7),
                64'(alu_control), 64'(dv[k].ctl));
            chk($sformatf("decode[%0d] is_mext", dn), 64'(is_mext), 64'(dv[k].mext));
            dn++;
        end
        alu_op = '0; funct3 = '0; funct7 = '0;

        // ---------------- M-op vectors ----------------
        @(posedge clk);
        #1;
        foreach (mv[k])
            do_mop(mv[k].nm, mv[k].f3, mv[k].a, mv[k].b, mv[k].res, mv[k].lat, 1'b0);
        // md_result now holds 2 (REMU 100/7)

        // ---------------- flush during CALC ----------------
        alu_op = 2'b10; funct7 = 7'b0000001; funct3 = 3'd0;
        operand_a = 32'd5; operand_b = 32'd6; md_req = 1'b1;
        @(posedge clk);              // accept edge E
        repeat (9) @(posedge clk);
        #1 flush = 1'b1;             // cycle E+10
        @(negedge clk);
        chk("flush calc busy", 64'(md_busy), 64'd1);
        chk("flush calc done", 64'(md_done), 64'd0);
        @(posedge clk);
        #1 flush = 1'b0; md_req = 1'b0; alu_op = 2'b00; funct7 = '0;
        @(negedge clk);
        chk("flush calc idle",   64'(md_busy),   64'd0);
        chk("flush calc result", 64'(md_result), 64'd2);
        dn = 0;
        repeat (40) begin
            @(negedge clk);
            if (md_done) dn++;
        end
        chk("flush calc no done", 64'(dn), 64'd0);
        chk("flush calc result later", 64'(md_result), 64'd2);

        // ---------------- flush during DONE ----------------
        @(posedge clk);
        #1;
        alu_op = 2'b10; funct7 = 7'b0000001; funct3 = 3'd5;
        operand_a = 32'h1234; operand_b = 32'd0; md_req = 1'b1;
        @(posedge clk);              // accept, straight to DONE
        #1 flush = 1'b1; md_req = 1'b0;
        @(negedge clk);
        chk("flush done busy",   64'(md_busy),   64'd1);
        chk("flush done done",   64'(md_done),   64'd0);
        chk("flush done result", 64'(md_result), 64'd2);
        @(posedge clk);
        #1 flush = 1'b0; alu_op = 2'b00; funct7 = '0;
        @(negedge clk);
        chk("flush done idle",   64'(md_busy),   64'd0);
        chk("flush done held",   64'(md_result), 64'd2);

        // ---------------- async reset mid-op ----------------
        @(posedge clk);
        #1;
        alu_op = 2'b10; funct7 = 7'b0000001; funct3 = 3'd0;
        operand_a = 32'd9; operand_b = 32'd9; md_req = 1'b1;
        @(posedge clk);              // accept E
        repeat (5) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("rst busy",   64'(md_busy),   64'd0);
        chk("rst done",   64'(md_done),   64'd0);
        chk("rst result", 64'(md_result), 64'd0);
        md_req = 1'b0; alu_op = 2'b00; funct7 = '0;
        @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;

        // ---------------- back-to-back ----------------
        do_mop("b2b MUL",  3'd0, 32'd3,   32'd4, 32'd12, 33, 1'b1);
        do_mop("b2b DIVU", 3'd5, 32'd100, 32'd7, 32'd14, 33, 1'b0);
        do_mop("b2b DIVU0",3'd5, 32'd1,   32'd0, 32'hFFFFFFFF, 1, 1'b1);
        do_mop("b2b MULHU",3'd3, 32'hFFFFFFFD, 32'd7, 32'd6, 33, 1'b0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule
